// File: rtl/serial_to_parallel_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
package s2p_pkg;

  typedef enum logic {
    S2P_IDLE  = 1'b0,
    S2P_SHIFT = 1'b1
  } s2p_state_e;

  // Bit-counter width for an n-bit word; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_to_parallel_if.sv
// Serial input / parallel output bundle for the deserializer.
interface serial_to_parallel_if #(
  parameter int N = 8
);
  logic         serial_in;
  logic         sync;
  logic         out_ready;
  logic         clear_flags;
  logic [N-1:0] data_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;
  logic         resync_err;

  // Upstream serializer and downstream consumer side.
  modport master (
    output serial_in, sync, out_ready, clear_flags,
    input  data_out, out_valid, busy, overrun, resync_err
  );

  // Deserializer side.
  modport slave (
    input  serial_in, sync, out_ready, clear_flags,
    output data_out, out_valid, busy, overrun, resync_err
  );
endinterface

// File: rtl/serial_to_parallel.sv
// Deserializer: collects N LSB-first bits aligned on sync into a word and
// presents it on a single-entry valid/ready output register. Words that
// complete while the register is still full are dropped (overrun); a sync
// in the middle of a word restarts collection (resync_err).
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int N = 8
) (
  input logic                clk,
  input logic                reset,
  serial_to_parallel_if.slave bus
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  s2p_state_e   state;
  logic [CW-1:0] bit_cnt;
  logic [N-1:0]  shreg;
  logic [N-1:0]  data_out;
  logic          out_valid;
  logic          overrun;
  logic          resync_err;
  logic          out_free;

  // Output register can take a new word when empty or draining this cycle.
  assign out_free = !out_valid || bus.out_ready;

  // Bit collection, output register, handshake and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S2P_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      // Clears first so that any set below in the same cycle wins.
      if (bus.clear_flags) begin
        overrun    <= 1'b0;
        resync_err <= 1'b0;
      end
      // Transfer with no load empties the register; a load below overrides.
      if (out_valid && bus.out_ready)
        out_valid <= 1'b0;

      case (state)
        S2P_IDLE: begin
          if (bus.sync) begin
            shreg   <= {{(N-1){1'b0}}, bus.serial_in};
            bit_cnt <= CW'(1);
            state   <= S2P_SHIFT;
          end
        end
        S2P_SHIFT: begin
          if (bus.sync) begin
            // Misaligned word: drop the partial bits and restart on bit 0.
            shreg      <= {{(N-1){1'b0}}, bus.serial_in};
            bit_cnt    <= CW'(1);
            resync_err <= 1'b1;
          end else if (bit_cnt == LAST) begin
            state   <= S2P_IDLE;
            bit_cnt <= '0;
            if (out_free) begin
              data_out  <= {bus.serial_in, shreg[N-2:0]};
              out_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            shreg[bit_cnt] <= bus.serial_in;
            bit_cnt        <= bit_cnt + CW'(1);
          end
        end
        default: state <= S2P_IDLE;
      endcase
    end
  end

  assign bus.data_out   = data_out;
  assign bus.out_valid  = out_valid;
  assign bus.overrun    = overrun;
  assign bus.resync_err = resync_err;
  assign bus.busy       = (state == S2P_SHIFT);

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel with N=8.
module tb_serial_to_parallel;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;

  serial_to_parallel_if #(.N(N)) bus ();

  serial_to_parallel #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] word;
    logic [N-1:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every transfer seen must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", bus.data_out);
      end else begin
        chk("sb_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  // One clock with the given inputs; returns #1 after the rising edge.
  task automatic cyc(input logic s, input logic b, input logic rdy);
    bus.sync      = s;
    bus.serial_in = b;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Send a full synced word; out_ready follows rdy, rdy_last on bit N-1.
  task automatic send_word(input logic [N-1:0] w, input logic rdy, input logic rdy_last);
    for (int i = 0; i < N; i++)
      cyc(i == 0, w[i], (i == N - 1) ? rdy_last : rdy);
  endtask

  task automatic clear_pulse();
    bus.clear_flags = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    bus.clear_flags = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h3C, 8'h3C};
    vecs[1] = '{8'hC3, 8'hC3};
    vecs[2] = '{8'h00, 8'h00};
    vecs[3] = '{8'hFF, 8'hFF};
    vecs[4] = '{8'h96, 8'h96};
    vecs[5] = '{8'h01, 8'h01};

    reset = 1'b1;
    bus.sync = 1'b0; bus.serial_in = 1'b0; bus.out_ready = 1'b0; bus.clear_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(bus.data_out), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_flags", 32'({bus.overrun, bus.resync_err}), 0);
    reset = 1'b0;
    cyc(1'b0, 1'b1, 1'b1);

    // Single word 0xA5: latency N clocks, valid for exactly one cycle.
    exp_q.push_back(8'hA5);
    for (int i = 0; i < N - 1; i++) cyc(i == 0, 1'((8'hA5 >> i) & 1), 1'b1);
    chk("single_early_valid", 32'(bus.out_valid), 0);
    chk("single_busy", 32'(bus.busy), 1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("single_valid", 32'(bus.out_valid), 1);
    chk("single_data", 32'(bus.data_out), 32'h A5);
    cyc(1'b0, 1'b0, 1'b1);
    chk("single_valid_drop", 32'(bus.out_valid), 0);
    chk("single_flags", 32'({bus.overrun, bus.resync_err}), 0);

    // Table: back-to-back words, next sync right after each completion.
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back(vecs[v].exp_data);
      send_word(vecs[v].word, 1'b1, 1'b1);
      chk("b2b_valid", 32'(bus.out_valid), 1);
      chk("b2b_data", 32'(bus.data_out), 32'(vecs[v].exp_data));
      chk("b2b_busy_gap", 32'(bus.busy), 0);
    end
    cyc(1'b0, 1'b0, 1'b1);
    chk("b2b_flags", 32'({bus.overrun, bus.resync_err}), 0);

    // Overrun: second word dropped while the first is held.
    exp_q.push_back(8'h11);
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    chk("ovr_data", 32'(bus.data_out), 32'h11);
    chk("ovr_valid", 32'(bus.out_valid), 1);
    chk("ovr_flag", 32'(bus.overrun), 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("ovr_hold", 32'(bus.data_out), 32'h11);
    cyc(1'b0, 1'b0, 1'b1);
    chk("ovr_drain", 32'(bus.out_valid), 0);
    chk("ovr_sticky", 32'(bus.overrun), 1);
    clear_pulse();
    chk("ovr_clear", 32'(bus.overrun), 0);

    // Same-cycle drain and load.
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b1);
    chk("sc_data", 32'(bus.data_out), 32'h22);
    chk("sc_valid", 32'(bus.out_valid), 1);
    chk("sc_overrun", 32'(bus.overrun), 0);
    cyc(1'b0, 1'b0, 1'b1);

    // Resync: partial word of 3 bits, then a full 0x5A.
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 1'b1, 1'b1);
    chk("rs_flag", 32'(bus.resync_err), 1);
    chk("rs_data", 32'(bus.data_out), 32'h5A);
    chk("rs_valid", 32'(bus.out_valid), 1);
    cyc(1'b0, 1'b0, 1'b1);
    // Set wins over a same-cycle clear.
    bus.clear_flags = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    bus.clear_flags = 1'b0;
    chk("rs_set_wins", 32'(bus.resync_err), 1);
    clear_pulse();
    chk("rs_clear", 32'(bus.resync_err), 0);
    // Finish the restarted word with nothing pending so it is held, not consumed.
    for (int i = 0; i < N; i++) cyc(i == 0, 1'b1, 1'b0);

    // Reset mid-word with a held word and a pending resync flag.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_data", 32'(bus.data_out), 0);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_flags", 32'({bus.overrun, bus.resync_err}), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < N + 2; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("nosync_valid", 32'(bus.out_valid), 0);
    chk("nosync_busy", 32'(bus.busy), 0);
    exp_q.push_back(8'h81);
    send_word(8'h81, 1'b1, 1'b1);
    chk("post_rst_data", 32'(bus.data_out), 32'h81);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

Deserializer that sits directly downstream of the team's parallel-to-serial stage. It collects N serial bits, LSB first, into a parallel word, using a frame-sync strobe to align on bit 0. Each completed word is presented on a single-entry valid/ready output register. Words that arrive while that register is still occupied are dropped and flagged as overrun; sync pulses that arrive mid-word are flagged as resync errors.

## Interface
- N, default 8: word width in bits; legal range N >= 2.
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high; returns the block to IDLE.
- serial_in  input  1  serial data bit, sampled every clock.
- sync  input  1  high in the cycle where bit 0 of a word is on serial_in.
- out_ready  input  1  downstream consumer accepts data_out this cycle.
- clear_flags  input  1  synchronous clear of overrun and resync_err.
- data_out  output  N  last completed word, held stable while out_valid=1.
- out_valid  output  1  data_out holds an unconsumed word.
- busy  output  1  a word is partially collected (state SHIFT).
- overrun  output  1  sticky: a completed word was dropped because the output register was full.
- resync_err  output  1  sticky: sync arrived before the current word was complete.

## Operation
- States: IDLE (waiting for sync) and SHIFT (collecting bits 1..N-1).
- Counter: bit_cnt, width $clog2(N); shift register: shreg[N-1:0].
- IDLE:
  - sync=1: shreg[0] <= serial_in, bit_cnt <= 1, go to SHIFT.
  - sync=0: hold; serial_in is ignored.
- SHIFT, sync=0: shreg[bit_cnt] <= serial_in, bit_cnt <= bit_cnt+1.
- SHIFT, sync=1 (misalignment):
  - Discard the partial word.
  - shreg[0] <= serial_in, bit_cnt <= 1, stay in SHIFT, set resync_err.
- Word completion: the SHIFT cycle with bit_cnt == N-1 and sync=0.
  - Go to IDLE, bit_cnt <= 0.
  - The completed word is {serial_in, shreg[N-2:0]}.
  - Load it into data_out when the output register is free: out_valid=0, or out_valid=1 with out_ready=1 this cycle. Set out_valid=1.
  - Otherwise drop the word, keep data_out unchanged, set overrun.
- Output handshake:
  - A transfer happens in a cycle where out_valid=1 and out_ready=1.
  - After a transfer with no new word loading, out_valid <= 0.
  - A transfer and a load in the same cycle keep out_valid=1 with the new data.
- Flags:
  - clear_flags clears overrun and resync_err.
  - If a set condition occurs in the same cycle as clear_flags, set wins.
- busy = (state == SHIFT).

## Timing
- Reset values: data_out=0, out_valid=0, busy=0, overrun=0, resync_err=0. Internal reset: state=IDLE, bit_cnt=0, shreg=0.
- Latency: if bit N-1 is on serial_in in cycle t, data_out and out_valid are updated at the rising edge ending cycle t. Bit 0 (with sync) to out_valid is N clocks.
- Back-to-back words: sync may be high in the cycle right after a completion cycle; IDLE accepts it. Sustained throughput is one word per N clocks, with no gap required.
- Reset asserted mid-word: the partial word is lost and all outputs return to reset values immediately (asynchronous). The first word after reset needs a fresh sync.
- data_out must not change while out_valid=1 and out_ready=0.
- out_valid does not depend combinationally on out_ready. The only combinational input-to-output path is none: all outputs are registered.

## Structure
- Shared package (s2p_pkg):
  - State typedef: enum {S2P_IDLE, S2P_SHIFT}.
  - Count-width function wrapping $clog2(N).
- Single module; no sub-module. The output register is small enough to keep inline.

## Test plan
All scenarios use N=8, bits sent LSB first.
- Single word: sync with bit 0 of 0xA5, out_ready=1 -> out_valid high for exactly 1 cycle, N clocks after bit 0, data_out=0xA5, no flags set.
- Back-to-back: 0x3C then 0xC3, the second sync in the cycle after the first word's bit 7, out_ready=1 -> out_valid pulses 8 clocks apart with 0x3C then 0xC3; busy low for one cycle between words.
- Overrun: out_ready=0, send 0x11 then 0x22 -> data_out stays 0x11, out_valid=1, overrun=1. Then pulse out_ready -> out_valid drops. Then pulse clear_flags -> overrun=0.
- Same-cycle drain and load: hold 0x11, assert out_ready only in word 0x22's completion cycle -> data_out=0x22, out_valid remains 1, overrun=0.
- Resync: sync, 3 bits, then sync with a full 0x5A -> resync_err=1, data_out=0x5A, no partial word emitted.
- Reset mid-word: assert reset after 4 bits of 0xFF -> outputs all 0 immediately. Bits without sync produce nothing. The next synced word 0x81 outputs 0x81.
